// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AES register slave AXI4-Lite port:
// response codes and the read-channel FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  localparam int RD_CNT_W = 3;

endpackage : axi_lite_pkg

// File: rtl/axi_lite_read.sv
// AXI4-Lite read-channel responder: one outstanding read, a single-cycle
// register-file strobe, fixed-latency capture, and a held R beat.
module axi_lite_read
  import axi_lite_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_RD_LATENCY = 1   // legal range 1..4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [C_ADDR_WIDTH-1:0] araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [C_DATA_WIDTH-1:0] rdata,
  output logic [1:0]              rresp,
  output logic [C_ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                    reg_rd_en,
  input  logic [C_DATA_WIDTH-1:0] reg_rd_data,
  input  logic                    reg_rd_err
);

  localparam logic [RD_CNT_W-1:0] CNT_LOAD = RD_CNT_W'(C_RD_LATENCY);

  rd_state_e                 state_q, state_d;
  logic [RD_CNT_W-1:0]       cnt_q, cnt_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [C_ADDR_WIDTH-1:0]   reg_rd_addr_q, reg_rd_addr_d;
  logic                      reg_rd_en_q, reg_rd_en_d;

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cnt_d         = cnt_q;
    arready_d     = arready_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    reg_rd_addr_d = reg_rd_addr_q;
    reg_rd_en_d   = 1'b0;

    unique case (state_q)
      RD_IDLE: begin
        // arready comes up one cycle after reset, so arvalid is ignored until then.
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          reg_rd_addr_d = araddr;
          reg_rd_en_d   = 1'b1;
          arready_d     = 1'b0;
          cnt_d         = CNT_LOAD;
          state_d       = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = reg_rd_data;
          rresp_d  = reg_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - RD_CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RD_IDLE;
      cnt_q         <= '0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= AXI_RESP_OKAY;
      reg_rd_addr_q <= '0;
      reg_rd_en_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rresp_q       <= rresp_d;
      reg_rd_addr_q <= reg_rd_addr_d;
      reg_rd_en_q   <= reg_rd_en_d;
    end
  end

  assign arready     = arready_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign reg_rd_addr = reg_rd_addr_q;
  assign reg_rd_en   = reg_rd_en_q;

endmodule : axi_lite_read

// File: tb/tb_axi_lite_read.sv
// Directed bench for axi_lite_read: four instances (latency 1..4), each
// backed by a small fixed-latency register-file model.
module tb_axi_lite_read;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0]  araddr_v      [N];
  logic        arvalid_v     [N];
  logic        arready_v     [N];
  logic        rvalid_v      [N];
  logic        rready_v      [N];
  logic [31:0] rdata_v       [N];
  logic [1:0]  rresp_v       [N];
  logic [9:0]  reg_rd_addr_v [N];
  logic        reg_rd_en_v   [N];
  logic [31:0] reg_rd_data_v [N];
  logic        reg_rd_err_v  [N];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] rf_data(input logic [9:0] a);
    case (a)
      10'h004: rf_data = 32'hDEAD_BEEF;
      10'h008: rf_data = 32'hCAFE_F00D;
      10'h010: rf_data = 32'h0000_0000;
      default: rf_data = {16'h1234, 6'h00, a};
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [3:0] pipe;
    // Register file answers exactly g+1 cycles after the strobe; garbage otherwise.
    always @(posedge clk) begin
      if (reset) pipe <= 4'b0;
      else       pipe <= {pipe[2:0], reg_rd_en_v[g]};
    end
    assign reg_rd_data_v[g] = pipe[g] ? rf_data(reg_rd_addr_v[g]) : 32'hBAD0_BAD0;
    assign reg_rd_err_v[g]  = pipe[g] ? (reg_rd_addr_v[g] == 10'h010) : 1'b1;

    axi_lite_read #(
      .C_ADDR_WIDTH(10),
      .C_DATA_WIDTH(32),
      .C_RD_LATENCY(g + 1)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .araddr      (araddr_v[g]),
      .arvalid     (arvalid_v[g]),
      .arready     (arready_v[g]),
      .rvalid      (rvalid_v[g]),
      .rready      (rready_v[g]),
      .rdata       (rdata_v[g]),
      .rresp       (rresp_v[g]),
      .reg_rd_addr (reg_rd_addr_v[g]),
      .reg_rd_en   (reg_rd_en_v[g]),
      .reg_rd_data (reg_rd_data_v[g]),
      .reg_rd_err  (reg_rd_err_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      arvalid_v[k] = 1'b0;
      rready_v[k]  = 1'b0;
      araddr_v[k]  = 10'h0;
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({arready_v[k], rvalid_v[k], reg_rd_en_v[k]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got arready/rvalid/en=%b%b%b expected 000", k, arready_v[k], rvalid_v[k], reg_rd_en_v[k]);
      end
      checks++;
      if ({rdata_v[k], rresp_v[k], reg_rd_addr_v[k]} !== 44'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got rdata=%h rresp=%b addr=%h expected zeros", k, rdata_v[k], rresp_v[k], reg_rd_addr_v[k]);
      end
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (arready_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_arready[%0d]: got %b expected 1", k, arready_v[k]);
      end
    end
  endtask

  task automatic test_basic();
    checks++;
    if (arready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_arready_c0: got %b expected 1", arready_v[0]);
    end
    araddr_v[0] = 10'h004; arvalid_v[0] = 1'b1; rready_v[0] = 1'b1;
    tick();  // cycle 1
    arvalid_v[0] = 1'b0;
    checks++;
    if ({reg_rd_en_v[0], reg_rd_addr_v[0], arready_v[0], rvalid_v[0]} !== {1'b1, 10'h004, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_c1: got en=%b addr=%h arready=%b rvalid=%b expected 1 004 0 0", reg_rd_en_v[0], reg_rd_addr_v[0], arready_v[0], rvalid_v[0]);
    end
    tick();  // cycle 2
    checks++;
    if ({reg_rd_en_v[0], rvalid_v[0]} !== 2'b00) begin
      errors++;
      $display("FAIL basic_c2: got en=%b rvalid=%b expected 0 0", reg_rd_en_v[0], rvalid_v[0]);
    end
    tick();  // cycle 3
    checks++;
    if ({rvalid_v[0], rdata_v[0], rresp_v[0], arready_v[0]} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL basic_c3: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 deadbeef 00 0", rvalid_v[0], rdata_v[0], rresp_v[0], arready_v[0]);
    end
    tick();  // cycle 4
    checks++;
    if ({rvalid_v[0], arready_v[0]} !== 2'b01) begin
      errors++;
      $display("FAIL basic_c4: got rvalid=%b arready=%b expected 0 1", rvalid_v[0], arready_v[0]);
    end
  endtask

  task automatic test_backpressure();
    araddr_v[0] = 10'h00C; arvalid_v[0] = 1'b1; rready_v[0] = 1'b0;
    tick();  // cycle 1
    arvalid_v[0] = 1'b0;
    tick();
    tick();  // cycle 3: rvalid rises
    araddr_v[0] = 10'h008; arvalid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid_v[0], rdata_v[0], rresp_v[0], arready_v[0], reg_rd_en_v[0]} !== {1'b1, 32'h1234_000C, 2'b00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rvalid=%b rdata=%h rresp=%b arready=%b en=%b expected 1 1234000c 00 0 0", i, rvalid_v[0], rdata_v[0], rresp_v[0], arready_v[0], reg_rd_en_v[0]);
      end
      tick();
    end
    rready_v[0] = 1'b1;  // cycle 8: R handshake
    checks++;
    if (rvalid_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_c8_rvalid: got %b expected 1", rvalid_v[0]);
    end
    tick();  // cycle 9: second AR accepted here
    checks++;
    if ({rvalid_v[0], arready_v[0]} !== 2'b01) begin
      errors++;
      $display("FAIL bp_c9: got rvalid=%b arready=%b expected 0 1", rvalid_v[0], arready_v[0]);
    end
    tick();  // cycle 10
    arvalid_v[0] = 1'b0;
    checks++;
    if ({reg_rd_en_v[0], reg_rd_addr_v[0]} !== {1'b1, 10'h008}) begin
      errors++;
      $display("FAIL bp_second_strobe: got en=%b addr=%h expected 1 008", reg_rd_en_v[0], reg_rd_addr_v[0]);
    end
    tick();
    tick();  // cycle 12
    checks++;
    if ({rvalid_v[0], rdata_v[0], rresp_v[0]} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
      errors++;
      $display("FAIL bp_second_beat: got rvalid=%b rdata=%h rresp=%b expected 1 cafef00d 00", rvalid_v[0], rdata_v[0], rresp_v[0]);
    end
    tick();
  endtask

  task automatic test_error();
    araddr_v[0] = 10'h010; arvalid_v[0] = 1'b1; rready_v[0] = 1'b1;
    tick();
    arvalid_v[0] = 1'b0;
    tick();
    tick();  // cycle 3
    checks++;
    if ({rvalid_v[0], rdata_v[0], rresp_v[0]} !== {1'b1, 32'h0, 2'b10}) begin
      errors++;
      $display("FAIL err_resp: got rvalid=%b rdata=%h rresp=%b expected 1 00000000 10", rvalid_v[0], rdata_v[0], rresp_v[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back(input int k);
    int lat;
    int n_hs;
    int n_beat;
    int n_en;
    int cyc;
    int hs_cyc [4];
    logic prev_rv;
    logic hs_now;
    logic [9:0]  addrs [4];
    logic [31:0] exp_d [4];
    addrs = '{10'h000, 10'h004, 10'h008, 10'h00C};
    exp_d = '{32'h1234_0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_000C};
    lat = k + 1;
    n_hs = 0; n_beat = 0; n_en = 0; cyc = 0; prev_rv = 1'b0;
    rready_v[k] = 1'b1; araddr_v[k] = addrs[0]; arvalid_v[k] = 1'b1;
    while (cyc < 60 && !(n_beat == 4 && !rvalid_v[k])) begin
      if (reg_rd_en_v[k]) n_en++;
      if (rvalid_v[k] && !prev_rv) begin
        checks++;
        if (n_beat >= n_hs || n_beat >= 4) begin
          errors++;
          $display("FAIL b2b_l%0d_spurious_beat: got beat %0d with %0d handshakes expected at most %0d", lat, n_beat, n_hs, n_hs);
        end else begin
          if (cyc - hs_cyc[n_beat] != lat + 2) begin
            errors++;
            $display("FAIL b2b_l%0d_rvalid_delay[%0d]: got %0d expected %0d", lat, n_beat, cyc - hs_cyc[n_beat], lat + 2);
          end
          checks++;
          if ({rdata_v[k], rresp_v[k]} !== {exp_d[n_beat], 2'b00}) begin
            errors++;
            $display("FAIL b2b_l%0d_data[%0d]: got %h/%b expected %h/00", lat, n_beat, rdata_v[k], rresp_v[k], exp_d[n_beat]);
          end
        end
        n_beat++;
      end
      prev_rv = rvalid_v[k];
      hs_now = arvalid_v[k] && arready_v[k];
      if (hs_now && n_hs < 4) begin
        if (n_hs > 0) begin
          checks++;
          if (cyc - hs_cyc[n_hs-1] != lat + 3) begin
            errors++;
            $display("FAIL b2b_l%0d_period[%0d]: got %0d expected %0d", lat, n_hs, cyc - hs_cyc[n_hs-1], lat + 3);
          end
        end
        hs_cyc[n_hs] = cyc;
        n_hs++;
      end
      tick();
      cyc++;
      if (hs_now) begin
        if (n_hs < 4) araddr_v[k] = addrs[n_hs];
        else          arvalid_v[k] = 1'b0;
      end
    end
    arvalid_v[k] = 1'b0;
    checks++;
    if (n_hs != 4 || n_beat != 4) begin
      errors++;
      $display("FAIL b2b_l%0d_count: got %0d handshakes %0d beats expected 4 4", lat, n_hs, n_beat);
    end
    checks++;
    if (n_en != 4) begin
      errors++;
      $display("FAIL b2b_l%0d_strobes: got %0d expected 4", lat, n_en);
    end
  endtask

  task automatic test_reset_mid();
    araddr_v[0] = 10'h004; arvalid_v[0] = 1'b1; rready_v[0] = 1'b1;
    tick();  // cycle 1
    arvalid_v[0] = 1'b0;
    checks++;
    if (reg_rd_en_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_strobe: got %b expected 1", reg_rd_en_v[0]);
    end
    tick();  // cycle 2 (WAIT)
    reset = 1'b1;
    tick();  // cycle 3
    checks++;
    if ({arready_v[0], rvalid_v[0], reg_rd_en_v[0], rdata_v[0], rresp_v[0], reg_rd_addr_v[0]} !== 47'h0) begin
      errors++;
      $display("FAIL rmid_reset_vals: got arready=%b rvalid=%b en=%b rdata=%h rresp=%b addr=%h expected zeros", arready_v[0], rvalid_v[0], reg_rd_en_v[0], rdata_v[0], rresp_v[0], reg_rd_addr_v[0]);
    end
    reset = 1'b0;
    tick();  // cycle 4
    checks++;
    if (arready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_arready: got %b expected 1", arready_v[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rvalid_v[0], reg_rd_en_v[0]} !== 2'b00) begin
        errors++;
        $display("FAIL rmid_quiet[%0d]: got rvalid=%b en=%b expected 0 0", i, rvalid_v[0], reg_rd_en_v[0]);
      end
      tick();
    end
    araddr_v[0] = 10'h008; arvalid_v[0] = 1'b1;
    tick();
    arvalid_v[0] = 1'b0;
    checks++;
    if ({reg_rd_en_v[0], reg_rd_addr_v[0]} !== {1'b1, 10'h008}) begin
      errors++;
      $display("FAIL rmid_new_strobe: got en=%b addr=%h expected 1 008", reg_rd_en_v[0], reg_rd_addr_v[0]);
    end
    tick();
    tick();
    checks++;
    if ({rvalid_v[0], rdata_v[0], rresp_v[0]} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin
      errors++;
      $display("FAIL rmid_new_beat: got rvalid=%b rdata=%h rresp=%b expected 1 cafef00d 00", rvalid_v[0], rdata_v[0], rresp_v[0]);
    end
    tick();
    checks++;
    if ({rvalid_v[0], arready_v[0]} !== 2'b01) begin
      errors++;
      $display("FAIL rmid_done: got rvalid=%b arready=%b expected 0 1", rvalid_v[0], arready_v[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    for (int k = 0; k < N; k++) test_back_to_back(k);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule : tb_axi_lite_read

// File: doc/axi_lite_read.md
# axi_lite_read

AXI4-Lite read-channel responder for the register slave of the AES core. It accepts one AR address at a time and issues a single-cycle read strobe to the register file. It waits a fixed register-file latency, then captures the data and holds it on the R channel until the master takes it. It pairs with the write-channel handler on the same slave port.

## Interface
- C_ADDR_WIDTH, 10, width of latched read address (low bits of araddr)
- C_DATA_WIDTH, 32, data width of rdata / reg_rd_data
- C_RD_LATENCY, 1, register-file read latency in cycles; legal range 1..4
- clk  in  1  clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high; clock clk
- araddr  in  C_ADDR_WIDTH  read address
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rvalid  out  1  R valid
- rready  in  1  R ready
- rdata  out  C_DATA_WIDTH  read data
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- reg_rd_addr  out  C_ADDR_WIDTH  register-file read address, held until the next AR handshake
- reg_rd_en  out  1  one-cycle register-file read strobe
- reg_rd_data  in  C_DATA_WIDTH  register-file data, valid C_RD_LATENCY cycles after the reg_rd_en cycle
- reg_rd_err  in  1  address-decode error, same timing as reg_rd_data

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: arready=1. On arvalid&arready:
  - reg_rd_addr<=araddr
  - reg_rd_en<=1 for exactly one cycle
  - arready<=0
  - cnt<=C_RD_LATENCY
  - state<=WAIT
- WAIT: cnt decrements each cycle. When cnt==0:
  - rdata<=reg_rd_data
  - rresp<=reg_rd_err ? 2'b10 : 2'b00
  - rvalid<=1
  - state<=RESP
- RESP: rvalid, rdata and rresp are held stable. On rvalid&rready:
  - rvalid<=0
  - arready<=1
  - state<=IDLE
- Only one outstanding read. arvalid is ignored outside IDLE because arready is low there.
- rready asserted before rvalid has no effect. rready already high when rvalid rises completes the handshake in the first rvalid cycle.
- The block never reads the register file speculatively. reg_rd_en pulses exactly once per AR handshake.
- cnt is 3 bits, unsigned, and does not wrap: the load value is 1..4 and decrement occurs only while cnt>0.

## Timing
- Reset values:
  - arready=0, rvalid=0, reg_rd_en=0
  - rdata=0, rresp=2'b00, reg_rd_addr=0
  - state=IDLE, cnt=0
- arready rises in the first cycle after reset deasserts.
- With the AR handshake in cycle 0:
  - reg_rd_en is high in cycle 1
  - data is sampled at the end of cycle 1+C_RD_LATENCY
  - rvalid rises in cycle C_RD_LATENCY+2
- With the R handshake in cycle N: arready=1 in cycle N+1. The next AR handshake can occur no earlier than cycle N+1.
- Minimum transaction period is C_RD_LATENCY+3 cycles (4 for the default).
- Reset asserted mid-transaction (WAIT or RESP) aborts it:
  - all outputs take reset values on the next edge
  - no R beat is issued
  - a reg_rd_en already issued is not repeated
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Shared package axi_lite_pkg:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10 (also used by the write handler)
  - state encoding constants RD_IDLE, RD_WAIT, RD_RESP
- No sub-modules. Single flat FSM with a latency counter.

## Test plan
- Basic read, C_RD_LATENCY=1, araddr=10'h004, register returns 32'hDEADBEEF, rready tied high:
  - reg_rd_en high in cycle 1 only, with reg_rd_addr=10'h004
  - rvalid in cycle 3 with rdata=32'hDEADBEEF, rresp=2'b00
  - arready back high in cycle 4
- Backpressure: rready held low 5 cycles after rvalid rises:
  - rvalid, rdata and rresp stay constant all 5 cycles
  - a second arvalid (araddr=10'h008) during this time is not accepted
  - it is accepted in the cycle after the R handshake
- Error response: reg_rd_err=1 with reg_rd_data=32'h0 at the sample cycle -> rresp=2'b10, rdata=32'h0.
- Latency sweep C_RD_LATENCY=1..4, back-to-back reads to 10'h000..10'h00C, rready high:
  - rvalid appears exactly L+2 cycles after each AR handshake
  - period between handshakes is L+3
  - exactly one reg_rd_en per read
- Reset mid-operation: reset asserted in cycle 2 (WAIT) of a read, then released:
  - rvalid never rises for the aborted read
  - all outputs are at reset values the cycle after reset asserts
  - arready=1 in the first cycle after release
  - a new read completes normally
